rssb_serial_ctrl: RTL and testbench
===================================

RSSB_SERIAL_CTRL -- requirements
Module: rssb_serial_ctrl

Interface
REQ-001 Parameter: WORD_W, default 8, operand/result word width in bits (legal range 1..32).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request one serial operation; sampled only in IDLE.
REQ-005 abort  in  1  synchronous cancel of an operation in progress.
REQ-006 op_word  in  WORD_W  operand, latched on accepted start.
REQ-007 busy  out  1  operation in progress.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 res_word  out  WORD_W  assembled serial result, held until next accepted start.
REQ-010 borrow  out  1  final cpu_flag (skip indication), held with res_word.
REQ-011 cpu_ph1, cpu_ph2  out  1 each  non-overlapping phase pulses to the 1-bit core.
REQ-012 cpu_rst  out  1  core reset, active-low.
REQ-013 cpu_ena  out  1  core enable.
REQ-014 cpu_data0  out  1  serial operand bit to the core.
REQ-015 cpu_result, cpu_flag  in  1 each  core result bit and borrow flag.

Function
REQ-016 The block SHALL use a 2-bit phase counter pc cycling 0,1,2,3 while busy, and held at 0 in IDLE.
REQ-017 cpu_ph1 SHALL be high exactly during pc==1 cycles, and cpu_ph2 exactly during pc==3 cycles; both SHALL be registered, glitch-free, and low in IDLE.
REQ-018 States: IDLE, CLR, SHIFT, DONE.
- IDLE->CLR on start.
- CLR->SHIFT after one 4-cycle phase period.
- SHIFT->DONE after WORD_W periods.
- DONE->IDLE after one cycle.
REQ-019 In CLR, cpu_rst SHALL be 0 and cpu_ena 0; in all other states cpu_rst SHALL be 1.
REQ-020 In SHIFT, cpu_ena SHALL be 1 and cpu_data0 SHALL equal the operand shift register bit 0 (LSB first), stable for the entire period.
REQ-021 On the clk edge terminating each SHIFT pc==3 cycle, the block SHALL:
- shift cpu_result into the result register MSB end;
- shift the operand register right;
- update cpu_data0.
REQ-022 On the edge capturing the last bit, borrow SHALL load cpu_flag.
REQ-023 Latency: with start sampled at edge E0, busy SHALL be high from E0 until E0+4*(WORD_W+1), and done SHALL be high for exactly the cycle following that edge (36 cycles after start for WORD_W=8).
REQ-024 start while busy SHALL be ignored without effect on the running operation.
REQ-025 res_word and borrow SHALL update only on completion, never with partial results.
REQ-026 abort while busy SHALL, at the next edge:
- return the block to IDLE with pc=0 and cpu_ena=0;
- assert no done;
- leave res_word and borrow unchanged.
REQ-027 abort and start together in IDLE: start SHALL win; abort in IDLE SHALL be ignored.
REQ-028 If done and start coincide, the start SHALL be ignored; a start is accepted only in IDLE.
REQ-029 WORD_W=1 SHALL yield one SHIFT period and a busy time of 8 cycles.

Reset
REQ-030 While rst is low, the block SHALL hold the following values, asynchronously and regardless of state: state=IDLE, pc=0, busy=0, done=0, res_word=0, borrow=0, cpu_ph1=0, cpu_ph2=0, cpu_ena=0, cpu_data0=0, cpu_rst=0.
REQ-031 After rst deasserts, cpu_rst SHALL return to 1 on the first clk edge.
REQ-032 rst asserted mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-033 Package rssb_pkg SHALL hold the state enum, the WORD_W default, and the constants PH1_SLOT=1 and PH2_SLOT=3.
REQ-034 Sub-module rssb_phase_gen SHALL contain the pc counter and the registered ph1/ph2 generation, with a run input; the FSM and shift registers remain at top level.

Verification
REQ-035 The bench core model SHALL be a serial subtractor computing 0 - operand: result bit = d^b, next b = d|b, flag = b, cleared by cpu_rst=0.
REQ-036 op_word=0x01, start -> done at cycle 36, res_word=0xFF, borrow=1; ph1/ph2 pulse 9 times each, never overlapping.
REQ-037 op_word=0x00 -> res_word=0x00, borrow=0; cpu_data0 is 0 throughout SHIFT.
REQ-038 op_word=0xA5 with start re-pulsed at cycle 10 -> a single done at cycle 36, res_word=0x5B, borrow=1.
REQ-039 abort at cycle 20 after a prior result of 0xFF -> busy low at cycle 21, no done, res_word stays 0xFF; a subsequent start runs normally.
REQ-040 rst pulled low at cycle 15 -> all outputs 0 immediately; after release the block accepts start and completes in 36 cycles.

Source files
------------

// File: rtl/rssb_pkg.sv
// Shared types and constants for the serial controller that sequences
// a 1-bit core through clear and shift phases.
package rssb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_W_DEFAULT = 8;

    // Phase slots within the 4-cycle period; PC_LAST ends each period.
    localparam logic [1:0] PH1_SLOT = 2'd1;
    localparam logic [1:0] PH2_SLOT = 2'd3;
    localparam logic [1:0] PC_LAST  = 2'd3;

endpackage

// File: rtl/rssb_phase_gen.sv
// Phase counter and registered, non-overlapping ph1/ph2 pulses for the core.
module rssb_phase_gen
    import rssb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [1:0] pc,
    output logic       ph1,
    output logic       ph2
);

    logic [1:0] pc_next;

    assign pc_next = pc + 2'd1;

    // Pulses decode the upcoming count so they line up with pc without a comb glitch path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= 2'd0;
            ph1 <= 1'b0;
            ph2 <= 1'b0;
        end else if (run) begin
            pc  <= pc_next;
            ph1 <= (pc_next == PH1_SLOT);
            ph2 <= (pc_next == PH2_SLOT);
        end else begin
            pc  <= 2'd0;
            ph1 <= 1'b0;
            ph2 <= 1'b0;
        end
    end

endmodule

// File: rtl/rssb_serial_ctrl.sv
// Serial operation controller: clears the 1-bit core, streams the operand
// LSB first, and assembles the returned bits into a result word.
module rssb_serial_ctrl
    import rssb_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] op_word,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] res_word,
    output logic              borrow,
    output logic              cpu_ph1,
    output logic              cpu_ph2,
    output logic              cpu_rst,
    output logic              cpu_ena,
    output logic              cpu_data0,
    input  logic              cpu_result,
    input  logic              cpu_flag
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t            state;
    state_t            state_next;
    logic [1:0]        pc;
    logic              run;
    logic              shift_edge;
    logic              last_bit;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] op_sr;
    logic [WORD_W-1:0] res_sr;
    logic [WORD_W-1:0] res_shift;

    assign run        = ((state == CLR) || (state == SHIFT)) && !abort;
    assign shift_edge = (state == SHIFT) && (pc == PC_LAST) && !abort;
    assign last_bit   = (bit_cnt == CNT_W'(WORD_W - 1));

    rssb_phase_gen u_phase_gen (
        .clk (clk),
        .rst (rst),
        .run (run),
        .pc  (pc),
        .ph1 (cpu_ph1),
        .ph2 (cpu_ph2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort only matters while busy, so a start in IDLE always wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLR;
            CLR: begin
                if (abort)               state_next = IDLE;
                else if (pc == PC_LAST)  state_next = SHIFT;
            end
            SHIFT: begin
                if (abort)                          state_next = IDLE;
                else if ((pc == PC_LAST) && last_bit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == CLR) || (state == SHIFT);
        done      = (state == DONE);
        cpu_ena   = (state == SHIFT);
        cpu_data0 = (state == SHIFT) && op_sr[0];
    end

    // Registered so the core stays in reset through the reset release edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rst <= 1'b0;
        end else begin
            cpu_rst <= (state_next != CLR);
        end
    end

    always_comb begin
        res_shift             = res_sr >> 1;
        res_shift[WORD_W-1]   = cpu_result;
    end

    // res_word and borrow only move on the final bit so partial results never escape.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_sr    <= '0;
            res_sr   <= '0;
            bit_cnt  <= '0;
            res_word <= '0;
            borrow   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            op_sr   <= op_word;
            bit_cnt <= '0;
        end else if (shift_edge) begin
            op_sr   <= op_sr >> 1;
            res_sr  <= res_shift;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
                res_word <= res_shift;
                borrow   <= cpu_flag;
            end
        end
    end

endmodule

// File: tb/tb_rssb_serial_ctrl.sv
// Directed bench for rssb_serial_ctrl driving a serial 0-minus-operand core model.
module tb_rssb_serial_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] op_word;
    logic       busy, done, borrow;
    logic [7:0] res_word;
    logic       cpu_ph1, cpu_ph2, cpu_rst, cpu_ena, cpu_data0;
    logic       cpu_result, cpu_flag;
    logic       core_b;

    logic       start1;
    logic [0:0] op1;
    logic       busy1, done1, borrow1;
    logic [0:0] res1;
    logic       ph1_1, ph2_1, rst_1, ena_1, data0_1;
    logic       result_1, flag_1;
    logic       core_b1;

    int n_tests = 0;
    int n_fail  = 0;

    int ph1_cnt = 0, ph2_cnt = 0, overlap_cnt = 0, data0_cnt = 0;
    int ph1_base, ph2_base, overlap_base, data0_base;
    int done_first, done_cnt, busy_err, busy_low_at;
    logic rst_clr, ena_clr, ena_shift;
    logic [7:0] res_mid;

    rssb_serial_ctrl #(.WORD_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .op_word    (op_word),
        .busy       (busy),
        .done       (done),
        .res_word   (res_word),
        .borrow     (borrow),
        .cpu_ph1    (cpu_ph1),
        .cpu_ph2    (cpu_ph2),
        .cpu_rst    (cpu_rst),
        .cpu_ena    (cpu_ena),
        .cpu_data0  (cpu_data0),
        .cpu_result (cpu_result),
        .cpu_flag   (cpu_flag)
    );

    rssb_serial_ctrl #(.WORD_W(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .abort      (1'b0),
        .op_word    (op1),
        .busy       (busy1),
        .done       (done1),
        .res_word   (res1),
        .borrow     (borrow1),
        .cpu_ph1    (ph1_1),
        .cpu_ph2    (ph2_1),
        .cpu_rst    (rst_1),
        .cpu_ena    (ena_1),
        .cpu_data0  (data0_1),
        .cpu_result (result_1),
        .cpu_flag   (flag_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial subtractor core: result = d ^ b, borrow advances on each ph2 of a shift period.
    assign cpu_result = cpu_data0 ^ core_b;
    assign cpu_flag   = core_b;
    always @(posedge clk) begin
        if (!cpu_rst)                core_b <= 1'b0;
        else if (cpu_ena && cpu_ph2) core_b <= cpu_data0 | core_b;
    end

    assign result_1 = data0_1 ^ core_b1;
    assign flag_1   = core_b1;
    always @(posedge clk) begin
        if (!rst_1)             core_b1 <= 1'b0;
        else if (ena_1 && ph2_1) core_b1 <= data0_1 | core_b1;
    end

    always @(negedge clk) begin
        if (cpu_ph1)              ph1_cnt     <= ph1_cnt + 1;
        if (cpu_ph2)              ph2_cnt     <= ph2_cnt + 1;
        if (cpu_ph1 && cpu_ph2)   overlap_cnt <= overlap_cnt + 1;
        if (cpu_ena && cpu_data0) data0_cnt   <= data0_cnt + 1;
    end

    // Stimulus driver: k counts edges after the accepting edge (k=0).
    task automatic run_op(input logic [7:0] op, input int restart_a, input int restart_b,
                          input int abort_k, input int n);
        ph1_base = ph1_cnt; ph2_base = ph2_cnt;
        overlap_base = overlap_cnt; data0_base = data0_cnt;
        op_word = op;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_word = 8'h33;
        done_first = -1; done_cnt = 0; busy_err = 0; busy_low_at = -1;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
            end
            if (done === 1'b1) begin
                if (done_first < 0) done_first = k;
                done_cnt++;
            end
            if (busy !== 1'b1 && busy_low_at < 0) busy_low_at = k;
            if (busy !== 1'(k < 36)) busy_err++;
            if (k == 1) begin rst_clr = cpu_rst; ena_clr = cpu_ena; end
            if (k == 10) ena_shift = cpu_ena;
            if (k == 20) res_mid = res_word;
            if (k == restart_a || k == restart_b) start = 1'b1;
            if (k == abort_k) abort = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; op_word = 8'h00;
        start1 = 1'b0; op1 = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, borrow, cpu_ph1, cpu_ph2, cpu_rst, cpu_ena, cpu_data0} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000000",
                     {busy, done, borrow, cpu_ph1, cpu_ph2, cpu_rst, cpu_ena, cpu_data0});
        end
        n_tests++;
        if (res_word !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_res: got %h expected 00", res_word);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (cpu_rst !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_cpu_rst_held: got %b expected 0", cpu_rst);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (cpu_rst !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_release_cpu_rst: got %b expected 1", cpu_rst);
        end
    endtask

    task automatic test_op01();
        run_op(8'h01, -1, -1, -1, 37);
        n_tests++;
        if (done_first !== 36 || done_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL op01_done: got cycle %0d count %0d expected 36/1", done_first, done_cnt);
        end
        n_tests++;
        if (busy_err !== 0) begin
            n_fail++; $display("[TB] FAIL op01_busy: got %0d bad cycles expected 0", busy_err);
        end
        n_tests++;
        if (res_word !== 8'hFF || borrow !== 1'b1) begin
            n_fail++; $display("[TB] FAIL op01_result: got %h/%b expected FF/1", res_word, borrow);
        end
        n_tests++;
        if (ph1_cnt - ph1_base !== 9 || ph2_cnt - ph2_base !== 9 || overlap_cnt - overlap_base !== 0) begin
            n_fail++; $display("[TB] FAIL op01_phases: got ph1 %0d ph2 %0d overlap %0d expected 9/9/0",
                               ph1_cnt - ph1_base, ph2_cnt - ph2_base, overlap_cnt - overlap_base);
        end
        n_tests++;
        if (rst_clr !== 1'b0 || ena_clr !== 1'b0 || ena_shift !== 1'b1) begin
            n_fail++; $display("[TB] FAIL op01_core_ctrl: got rst %b ena %b/%b expected 0 0/1", rst_clr, ena_clr, ena_shift);
        end
        n_tests++;
        if (res_mid !== 8'h00) begin
            n_fail++; $display("[TB] FAIL op01_partial: got %h expected 00", res_mid);
        end
        n_tests++;
        if (data0_cnt - data0_base !== 4) begin
            n_fail++; $display("[TB] FAIL op01_data0: got %0d high cycles expected 4", data0_cnt - data0_base);
        end
    endtask

    task automatic test_abort();
        int seen;
        int first;
        run_op(8'h00, -1, -1, 20, 21);
        n_tests++;
        if (busy_low_at !== 21) begin
            n_fail++; $display("[TB] FAIL abort_busy_low: got cycle %0d expected 21", busy_low_at);
        end
        n_tests++;
        if ({cpu_ena, cpu_ph1, cpu_ph2} !== 3'b000) begin
            n_fail++; $display("[TB] FAIL abort_core_idle: got %b expected 000", {cpu_ena, cpu_ph1, cpu_ph2});
        end
        seen = done_cnt;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0 || res_word !== 8'hFF || borrow !== 1'b1) begin
            n_fail++; $display("[TB] FAIL abort_hold: got done %0d res %h/%b expected 0 FF/1", seen, res_word, borrow);
        end
        op_word = 8'h01; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL abort_start_wins: got busy %b expected 1", busy);
        end
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 && first < 0) first = k;
        end
        n_tests++;
        if (first !== 36 || res_word !== 8'hFF) begin
            n_fail++; $display("[TB] FAIL abort_rerun: got cycle %0d res %h expected 36 FF", first, res_word);
        end
    endtask

    task automatic test_zero();
        run_op(8'h00, -1, -1, -1, 37);
        n_tests++;
        if (done_first !== 36 || res_word !== 8'h00 || borrow !== 1'b0) begin
            n_fail++; $display("[TB] FAIL zero_result: got cycle %0d res %h/%b expected 36 00/0", done_first, res_word, borrow);
        end
        n_tests++;
        if (data0_cnt - data0_base !== 0) begin
            n_fail++; $display("[TB] FAIL zero_data0: got %0d high cycles expected 0", data0_cnt - data0_base);
        end
    endtask

    task automatic test_back_to_back();
        run_op(8'hA5, 10, 36, -1, 40);
        n_tests++;
        if (done_first !== 36 || done_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL restart_done: got cycle %0d count %0d expected 36/1", done_first, done_cnt);
        end
        n_tests++;
        if (busy_err !== 0) begin
            n_fail++; $display("[TB] FAIL restart_busy: got %0d bad cycles expected 0", busy_err);
        end
        n_tests++;
        if (res_word !== 8'h5B || borrow !== 1'b1) begin
            n_fail++; $display("[TB] FAIL restart_result: got %h/%b expected 5B/1", res_word, borrow);
        end
    endtask

    task automatic test_rst_mid();
        op_word = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, borrow, cpu_ph1, cpu_ph2, cpu_rst, cpu_ena, cpu_data0} !== 8'h00 || res_word !== 8'h00) begin
            n_fail++; $display("[TB] FAIL rst_mid_outputs: got %b res %h expected 00000000 00",
                               {busy, done, borrow, cpu_ph1, cpu_ph2, cpu_rst, cpu_ena, cpu_data0}, res_word);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (cpu_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rst_mid_release: got rst %b busy %b done %b expected 1 0 0", cpu_rst, busy, done);
        end
        run_op(8'h01, -1, -1, -1, 37);
        n_tests++;
        if (done_first !== 36 || res_word !== 8'hFF) begin
            n_fail++; $display("[TB] FAIL rst_mid_rerun: got cycle %0d res %h expected 36 FF", done_first, res_word);
        end
    endtask

    task automatic test_width1();
        int bad;
        int first;
        bad = 0; first = -1;
        op1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy1 !== 1'(k < 8)) bad++;
            if (done1 === 1'b1 && first < 0) first = k;
        end
        n_tests++;
        if (bad !== 0 || first !== 8) begin
            n_fail++; $display("[TB] FAIL width1_timing: got %0d bad busy, done at %0d expected 0, 8", bad, first);
        end
        n_tests++;
        if (res1 !== 1'b1) begin
            n_fail++; $display("[TB] FAIL width1_result: got %b expected 1", res1);
        end
    endtask

    initial begin
        test_reset();
        test_op01();
        test_abort();
        test_zero();
        test_back_to_back();
        test_rst_mid();
        test_width1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
